// File: rtl/fpusqr_wb_queue.sv
// Writeback staging FIFO behind the FP sqrt/divide unit: buffers alternate-port
// results and replays them in order whenever the shared FP writeback slot is idle.
module fpusqr_wb_queue #(
  parameter int DEPTH      = 4,
  parameter int SIMD_WIDTH = 68
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         except,
  input  logic [3:0]                   in_en,
  input  logic [9:0]                   in_II,
  input  logic [12:0]                  in_op,
  input  logic [8:0]                   in_reg,
  input  logic [8:0]                   in_sreg,
  input  logic                         in_wen,
  input  logic [16+SIMD_WIDTH-1:0]     in_dataF,
  input  logic [SIMD_WIDTH-1:0]        in_dataV,
  input  logic                         wb_busy,
  output logic [3:0]                   out_en,
  output logic [9:0]                   out_II,
  output logic [12:0]                  out_op,
  output logic [8:0]                   out_reg,
  output logic [8:0]                   out_sreg,
  output logic                         out_wen,
  output logic [16+SIMD_WIDTH-1:0]     out_dataF,
  output logic [SIMD_WIDTH-1:0]        out_dataV,
  output logic                         pause,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = 16 + SIMD_WIDTH;
  localparam int EW = 4 + 10 + 13 + 9 + 9 + 1 + FW + SIMD_WIDTH;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] PAUSE_CNT = CW'(DEPTH - 1);

  logic [EW-1:0]   entry_mem [DEPTH];
  logic [AW-1:0]   head_reg, tail_reg;
  logic [CW-1:0]   count_reg;
  logic            ovf_reg;
  logic [3:0]      out_en_reg;
  logic [9:0]      out_II_reg;
  logic [12:0]     out_op_reg;
  logic [8:0]      out_reg_reg, out_sreg_reg;
  logic            out_wen_reg;
  logic [FW-1:0]   out_dataF_reg;
  logic [SIMD_WIDTH-1:0] out_dataV_reg;

  logic            push_req, pop, push_ok, drop;
  logic [EW-1:0]   wr_word, rd_word;

  logic [3:0]      rd_en;
  logic [9:0]      rd_II;
  logic [12:0]     rd_op;
  logic [8:0]      rd_reg, rd_sreg;
  logic            rd_wen;
  logic [FW-1:0]   rd_dataF;
  logic [SIMD_WIDTH-1:0] rd_dataV;

  assign push_req = (in_en != 4'h0) && !except;
  assign pop      = (count_reg != '0) && !wb_busy && !except;
  // A full queue still accepts a push when an entry leaves in the same cycle.
  assign push_ok  = push_req && ((count_reg != FULL_CNT) || pop);
  assign drop     = push_req && !push_ok;

  assign wr_word = {in_en, in_II, in_op, in_reg, in_sreg, in_wen, in_dataF, in_dataV};
  assign rd_word = entry_mem[head_reg];
  assign {rd_en, rd_II, rd_op, rd_reg, rd_sreg, rd_wen, rd_dataF, rd_dataV} = rd_word;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      entry_mem[tail_reg] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      out_en_reg    <= '0;
      out_II_reg    <= '0;
      out_op_reg    <= '0;
      out_reg_reg   <= '0;
      out_sreg_reg  <= '0;
      out_wen_reg   <= 1'b0;
      out_dataF_reg <= '0;
      out_dataV_reg <= '0;
    end else if (except) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      out_en_reg  <= '0;
      out_wen_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        tail_reg <= tail_reg + AW'(1);
      end
      if (pop) begin
        head_reg      <= head_reg + AW'(1);
        out_en_reg    <= rd_en;
        out_II_reg    <= rd_II;
        out_op_reg    <= rd_op;
        out_reg_reg   <= rd_reg;
        out_sreg_reg  <= rd_sreg;
        out_wen_reg   <= rd_wen;
        out_dataF_reg <= rd_dataF;
        out_dataV_reg <= rd_dataV;
      end else begin
        out_en_reg  <= '0;
        out_wen_reg <= 1'b0;
      end
      if (push_ok && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push_ok) begin
        count_reg <= count_reg - CW'(1);
      end
      if (drop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign out_en    = out_en_reg;
  assign out_II    = out_II_reg;
  assign out_op    = out_op_reg;
  assign out_reg   = out_reg_reg;
  assign out_sreg  = out_sreg_reg;
  assign out_wen   = out_wen_reg;
  assign out_dataF = out_dataF_reg;
  assign out_dataV = out_dataV_reg;
  assign count     = count_reg;
  assign ovf       = ovf_reg;
  // Leaves room for the one push already in flight when upstream sees pause.
  assign pause     = (count_reg >= PAUSE_CNT);

endmodule

// File: tb/tb_fpusqr_wb_queue.sv
// Bench for fpusqr_wb_queue: scoreboard of pushed results checked on every out_en
// pulse, a table-driven wrap-around run, and directed corner-case sequences.
module tb_fpusqr_wb_queue;

  localparam int SW = 68;

  logic          clk = 1'b0;
  logic          rst, except, in_wen, wb_busy;
  logic [3:0]    in_en;
  logic [9:0]    in_II;
  logic [12:0]   in_op;
  logic [8:0]    in_reg, in_sreg;
  logic [16+SW-1:0] in_dataF;
  logic [SW-1:0] in_dataV;
  logic [3:0]    out_en;
  logic [9:0]    out_II;
  logic [12:0]   out_op;
  logic [8:0]    out_reg, out_sreg;
  logic          out_wen, pause, ovf;
  logic [16+SW-1:0] out_dataF;
  logic [SW-1:0] out_dataV;
  logic [2:0]    count;

  fpusqr_wb_queue #(.DEPTH(4), .SIMD_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .except(except), .in_en(in_en), .in_II(in_II),
    .in_op(in_op), .in_reg(in_reg), .in_sreg(in_sreg), .in_wen(in_wen),
    .in_dataF(in_dataF), .in_dataV(in_dataV), .wb_busy(wb_busy),
    .out_en(out_en), .out_II(out_II), .out_op(out_op), .out_reg(out_reg),
    .out_sreg(out_sreg), .out_wen(out_wen), .out_dataF(out_dataF),
    .out_dataV(out_dataV), .pause(pause), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    en;
    logic [9:0]    ii;
    logic [12:0]   op;
    logic [8:0]    rg;
    logic [8:0]    sreg;
    logic          wen;
    logic [16+SW-1:0] df;
    logic [SW-1:0] dv;
  } res_t;

  typedef struct {
    logic       push;
    logic       busy;
    logic [2:0] exp_count;
  } vec_t;

  res_t sb[$];
  res_t mon_e;
  vec_t tbl[17];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input res_t r, input logic push, input logic busy,
                      input logic exc, input logic accept);
    in_en    = push ? r.en : 4'h0;
    in_II    = r.ii;
    in_op    = r.op;
    in_reg   = r.rg;
    in_sreg  = r.sreg;
    in_wen   = r.wen;
    in_dataF = r.df;
    in_dataV = r.dv;
    wb_busy  = busy;
    except   = exc;
    if (push && accept) sb.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic push, input logic busy, input logic exc,
                       input logic [9:0] ii, input logic accept);
    res_t r;
    r.en   = 4'($urandom_range(1, 15));
    r.ii   = ii;
    r.op   = 13'($urandom);
    r.rg   = 9'($urandom);
    r.sreg = 9'($urandom);
    r.wen  = 1'($urandom);
    r.df   = {20'($urandom), 32'($urandom), 32'($urandom)};
    r.dv   = {4'($urandom), 32'($urandom), 32'($urandom)};
    send(r, push, busy, exc, accept);
  endtask

  // Every replayed result must match the oldest outstanding push bit-exact.
  always @(negedge clk) begin
    if (!rst && out_en != 4'h0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got out_II=%0h expected no output", out_II);
      end else begin
        mon_e = sb.pop_front();
        chk("mon_en",    128'(out_en),    128'(mon_e.en));
        chk("mon_II",    128'(out_II),    128'(mon_e.ii));
        chk("mon_op",    128'(out_op),    128'(mon_e.op));
        chk("mon_reg",   128'(out_reg),   128'(mon_e.rg));
        chk("mon_sreg",  128'(out_sreg),  128'(mon_e.sreg));
        chk("mon_wen",   128'(out_wen),   128'(mon_e.wen));
        chk("mon_dataF", 128'(out_dataF), 128'(mon_e.df));
        chk("mon_dataV", 128'(out_dataV), 128'(mon_e.dv));
      end
    end
  end

  initial begin
    res_t fixed;

    tbl[0]  = '{1'b1, 1'b1, 3'd1};
    tbl[1]  = '{1'b1, 1'b0, 3'd1};
    tbl[2]  = '{1'b0, 1'b1, 3'd1};
    tbl[3]  = '{1'b1, 1'b0, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 3'd0};
    tbl[5]  = '{1'b1, 1'b1, 3'd1};
    tbl[6]  = '{1'b1, 1'b1, 3'd2};
    tbl[7]  = '{1'b1, 1'b0, 3'd2};
    tbl[8]  = '{1'b0, 1'b0, 3'd1};
    tbl[9]  = '{1'b1, 1'b0, 3'd1};
    tbl[10] = '{1'b1, 1'b1, 3'd2};
    tbl[11] = '{1'b0, 1'b0, 3'd1};
    tbl[12] = '{1'b0, 1'b0, 3'd0};
    tbl[13] = '{1'b1, 1'b0, 3'd1};
    tbl[14] = '{1'b1, 1'b1, 3'd2};
    tbl[15] = '{1'b0, 1'b0, 3'd1};
    tbl[16] = '{1'b0, 1'b0, 3'd0};

    rst = 1'b1; except = 1'b0; wb_busy = 1'b0; in_en = '0; in_II = '0; in_op = '0;
    in_reg = '0; in_sreg = '0; in_wen = 1'b0; in_dataF = '0; in_dataV = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",  128'(count),  128'(0));
    chk("rst_out_en", 128'(out_en), 128'(0));
    chk("rst_ovf",    128'(ovf),    128'(0));
    chk("rst_pause",  128'(pause),  128'(0));
    chk("rst_out_II", 128'(out_II), 128'(0));
    rst = 1'b0;

    // single result, minimum latency
    fixed = '{en: 4'h9, ii: 10'h05, op: 13'h0abc, rg: 9'h21, sreg: 9'h033,
              wen: 1'b1, df: 84'h1_2345, dv: 68'h0_dead_beef};
    send(fixed, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("single_t1_out_en", 128'(out_en), 128'(0));
    chk("single_t1_count",  128'(count),  128'(1));
    drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
    chk("single_t2_out_en", 128'(out_en),    128'(4'h9));
    chk("single_t2_II",     128'(out_II),    128'(10'h05));
    chk("single_t2_reg",    128'(out_reg),   128'(9'h21));
    chk("single_t2_dataF",  128'(out_dataF), 128'(84'h1_2345));
    drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
    chk("single_t3_out_en", 128'(out_en), 128'(0));
    chk("single_t3_count",  128'(count),  128'(0));

    // back-pressure
    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b1, 1'b0, 10'(i), 1'b1);
    chk("bp_count", 128'(count), 128'(3));
    chk("bp_pause", 128'(pause), 128'(1));
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
      chk("bp_out_II", 128'(out_II), 128'(i));
      chk("bp_count_drain", 128'(count), 128'(3 - i));
      chk("bp_pause_drain", 128'(pause), 128'(0));
    end

    // overflow: fifth push dropped, ovf sticky
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b1, 1'b0, 10'(i), 1'b1);
    chk("ovf_full_count", 128'(count), 128'(4));
    chk("ovf_before",     128'(ovf),   128'(0));
    drive(1'b1, 1'b1, 1'b0, 10'd5, 1'b0);
    chk("ovf_drop_count", 128'(count), 128'(4));
    chk("ovf_set",        128'(ovf),   128'(1));
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
      chk("ovf_out_II", 128'(out_II), 128'(i));
    end
    drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
    chk("ovf_no_fifth", 128'(out_en), 128'(0));
    chk("ovf_sticky",   128'(ovf),    128'(1));
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
    rst = 1'b0;
    chk("ovf_rst_clear", 128'(ovf), 128'(0));

    // push and pop together while full
    for (int i = 21; i <= 24; i++) drive(1'b1, 1'b1, 1'b0, 10'(i), 1'b1);
    chk("full_pause", 128'(pause), 128'(1));
    drive(1'b1, 1'b0, 1'b0, 10'd25, 1'b1);
    chk("full_pp_count", 128'(count),  128'(4));
    chk("full_pp_ovf",   128'(ovf),    128'(0));
    chk("full_pp_II",    128'(out_II), 128'(21));
    for (int i = 22; i <= 25; i++) begin
      drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
      chk("full_drain_II", 128'(out_II), 128'(i));
    end
    chk("full_drain_count", 128'(count), 128'(0));

    // flush with a concurrent push
    for (int i = 31; i <= 33; i++) drive(1'b1, 1'b1, 1'b0, 10'(i), 1'b1);
    drive(1'b1, 1'b1, 1'b1, 10'd34, 1'b0);
    sb.delete();
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_pause", 128'(pause), 128'(0));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
      chk("flush_no_out", 128'(out_en), 128'(0));
    end

    // wrap-around table
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].push, tbl[i].busy, 1'b0, 10'(100 + i), 1'b1);
      chk("wrap_count", 128'(count), 128'(tbl[i].exp_count));
    end

    // reset mid-stream
    drive(1'b1, 1'b1, 1'b0, 10'd60, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 10'd61, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 10'd62, 1'b0);
    rst = 1'b0;
    sb.delete();
    chk("midrst_count",  128'(count),  128'(0));
    chk("midrst_out_en", 128'(out_en), 128'(0));
    chk("midrst_ovf",    128'(ovf),    128'(0));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
    chk("midrst_idle_out", 128'(out_en), 128'(0));
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpusqr_wb_queue.md
Name: fpusqr_wb_queue

Overview:
- Writeback staging queue directly downstream of the FP square-root/divide unit.
- Captures each result the unit emits on its alternate output port: enables, II, op, destination regs, wen, and the F and V data halves.
- Holds results until the shared FP writeback slot is free, then replays them in order.
- Drives a pause back to the sqrt unit's issue side so the queue never overflows in normal operation.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- SIMD_WIDTH, 68, width of the V data half; F data is 16+SIMD_WIDTH bits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- except  input  1  pipeline flush; discards all queued and in-flight results
- in_en  input  4  result enables from sqrt unit; nonzero = push request
- in_II  input  10  instruction index
- in_op  input  13  operation code
- in_reg  input  9  destination register
- in_sreg  input  9  secondary destination register
- in_wen  input  1  register write enable
- in_dataF  input  16+SIMD_WIDTH  F result half
- in_dataV  input  SIMD_WIDTH  V result half
- wb_busy  input  1  main writeback slot is occupied this cycle; no pop allowed
- out_en  output  4  replayed result enables, one-cycle pulse
- out_II  output  10
- out_op  output  13
- out_reg  output  9
- out_sreg  output  9
- out_wen  output  1
- out_dataF  output  16+SIMD_WIDTH
- out_dataV  output  SIMD_WIDTH
- pause  output  1  upstream must not issue a new result-producing op
- count  output  $clog2(DEPTH)+1  current occupancy (debug/perf)
- ovf  output  1  sticky overflow error flag

Behaviour:
- Reset (rst=1 at a clk edge):
  - head, tail and count cleared to 0.
  - out_en=0, out_wen=0, ovf=0.
  - All other out_* registers cleared to 0.
  - Storage array is not reset.
- Push:
  - Occurs when in_en!=0 and except=0.
  - Writes all in_* fields to entry[tail]; tail=(tail+1) mod DEPTH.
- Pop:
  - Occurs when count>0, wb_busy=0 and except=0.
  - entry[head] is registered into the out_* fields at that edge; head=(head+1) mod DEPTH.
  - out_en is nonzero for exactly one cycle per popped entry.
- Output register:
  - Any cycle without a pop loads out_en=0 and out_wen=0.
  - All other out_* fields hold their previous value.
- Latency:
  - Push at edge T makes the entry eligible at T+1; earliest appearance on out_* is the cycle after edge T+1.
  - Minimum latency is 2 cycles; no same-cycle bypass.
- Count updates:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged; both pointers advance.
- Pause:
  - pause = (count >= DEPTH-1), combinational from registered count.
  - Upstream honours pause with one cycle of latency, so one extra push while count==DEPTH-1 fits.
- Full (count==DEPTH):
  - A push with no simultaneous pop is dropped; the queue is not modified and ovf is set to 1.
  - ovf stays 1 until rst.
  - A push with a simultaneous pop while full is accepted normally.
- Empty (count==0):
  - No pop; out_en=0 regardless of wb_busy.
- except:
  - At the edge where except=1: head=tail=count=0, out_en=0, out_wen=0.
  - A concurrent push is discarded.
  - ovf is unaffected.
  - pause deasserts the following cycle.
- Reset mid-operation: rst overrides except, push and pop; the queue empties and the state equals post-reset.
- Pointer wrap: head and tail wrap modulo DEPTH. count, not pointer equality, distinguishes full from empty.
- Ordering: strict FIFO; results leave in push order.
- No field transformation: out_* equal the pushed in_* fields bit-exact.

Test Plan:
- Single result: push in_II=10'h05, in_reg=9'h21, in_dataF=84'h1_2345, wb_busy=0 -> out_en matches in_en and fields match exactly, 2 cycles later, for 1 cycle; count returns to 0.
- Back-pressure: hold wb_busy=1 and push 3 results (II=1,2,3) -> count=3 and pause=1 after the third. Release wb_busy -> out_II=1,2,3 on consecutive cycles; pause drops once count<=2.
- Overflow: wb_busy=1, push 5 results with DEPTH=4 -> count=4, fifth dropped, ovf=1 and sticky. Release -> exactly II 1..4 emitted.
- Simultaneous push/pop at full: count=4 and wb_busy=0 with a push in the same cycle -> count stays 4, ovf=0, order preserved.
- Flush: 3 entries queued plus a push with except=1 -> count=0 next cycle, no out_en pulses afterwards, pause=0.
- Wrap-around: 10 push/pop pairs with alternating wb_busy -> all II values emitted in order across pointer wrap; rst asserted mid-stream -> count=0, out_en=0, ovf=0 next cycle.
